// File: rtl/tff_counter_pkg.sv
// Shared constants and helpers for the toggle-flop counter family.
// Used by tff_counter and tff_bit; see tff_counter.sv for SIM_C2Q_DELAY_EN.
package tff_counter_pkg;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SAT      = 1;
    localparam int C2Q_DELAY_DEF = 2;
    localparam int WIDTH_MIN     = 2;
    localparam int WIDTH_MAX     = 32;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_STEP,
        OP_LOAD,
        OP_CLR
    } op_e;

    function automatic logic [31:0] max_val(input int width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/tff_bit.sv
// Single toggle flop with async active-low reset to a per-bit value.
// SIM_C2Q_DELAY_EN adds a clock-to-Q delay to the non-reset update.
module tff_bit
    import tff_counter_pkg::*;
#(
    parameter logic RST_VAL   = 1'b0,
    parameter int   C2Q_DELAY = C2Q_DELAY_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    if (C2Q_DELAY < 0) begin : g_bad_delay
        $fatal(1, "tff_bit: C2Q_DELAY must be non-negative");
    end

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= RST_VAL;
        end else begin
`ifdef SIM_C2Q_DELAY_EN
            q_q <= #(C2Q_DELAY * 1ns) q_d;
`else
            q_q <= q_d;
`endif
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_counter.sv
// Up/down counter built from a chain of toggle flops, wrap or saturate.
// Optional macro SIM_C2Q_DELAY_EN delays q/wrap updates by C2Q_DELAY ns.
module tff_counter
    import tff_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SATURATE  = MODE_WRAP,
    parameter int RESET_VAL = 0,
    parameter int C2Q_DELAY = C2Q_DELAY_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(max_val(WIDTH));
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
    localparam logic             SAT   = (SATURATE == MODE_SAT);

    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
        $fatal(1, "tff_counter: WIDTH %0d out of range 2..32", WIDTH);
    end
    if ((RESET_VAL < 0) ||
        (longint'(RESET_VAL) > longint'(max_val(WIDTH)))) begin : g_bad_rst
        $fatal(1, "tff_counter: RESET_VAL does not fit in WIDTH");
    end
    if ((SATURATE != MODE_WRAP) && (SATURATE != MODE_SAT)) begin : g_bad_mode
        $fatal(1, "tff_counter: SATURATE must be 0 or 1");
    end

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] t_step;
    logic [WIDTH-1:0] t_mask;
    logic             tc_c;
    logic             wrap_q;
    logic             wrap_d;
    op_e              op;

    always_comb begin
        tc_c = en & (up_dn ? (q_w == MAX_V) : (q_w == '0));

        // Carry/borrow chain: a bit flips when every lower bit sits at
        // the stepping boundary (all ones up, all zeros down).
        t_step[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t_step[i] = t_step[i-1] & (up_dn ? q_w[i-1] : ~q_w[i-1]);
        end

        op = OP_HOLD;
        priority case (1'b1)
            clr:     op = OP_CLR;
            load:    op = OP_LOAD;
            en:      op = OP_STEP;
            default: op = OP_HOLD;
        endcase

        t_mask = '0;
        wrap_d = 1'b0;
        unique case (op)
            OP_CLR:  t_mask = q_w ^ RST_V;
            OP_LOAD: t_mask = q_w ^ d;
            OP_STEP: begin
                if (tc_c && SAT) begin
                    t_mask = '0;
                end else begin
                    t_mask = t_step;
                    wrap_d = tc_c;
                end
            end
            OP_HOLD: t_mask = '0;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_bit #(
            .RST_VAL   (RST_V[i]),
            .C2Q_DELAY (C2Q_DELAY)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .t       (t_mask[i]),
            .q       (q_w[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
        end else begin
`ifdef SIM_C2Q_DELAY_EN
            wrap_q <= #(C2Q_DELAY * 1ns) wrap_d;
`else
            wrap_q <= wrap_d;
`endif
        end
    end

    assign q    = q_w;
    assign tc   = tc_c;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_counter.sv
// Scoreboard bench: a 4-bit wrapping counter and a 3-bit saturating
// counter (reset value 5) share stimulus and are checked against a model.
module tb_tff_counter;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       up_dn;
    logic       clr;
    logic       load;
    logic [3:0] d;
    logic [3:0] q_w;
    logic       tc_w;
    logic       wrap_w;
    logic [2:0] q_s;
    logic       tc_s;
    logic       wrap_s;

    tff_counter #(
        .WIDTH     (4),
        .SATURATE  (0),
        .RESET_VAL (0)
    ) u_wrap (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .up_dn   (up_dn),
        .clr     (clr),
        .load    (load),
        .d       (d),
        .q       (q_w),
        .tc      (tc_w),
        .wrap    (wrap_w)
    );

    tff_counter #(
        .WIDTH     (3),
        .SATURATE  (1),
        .RESET_VAL (5)
    ) u_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .up_dn   (up_dn),
        .clr     (clr),
        .load    (load),
        .d       (d[2:0]),
        .q       (q_s),
        .tc      (tc_s),
        .wrap    (wrap_s)
    );

    typedef struct {
        logic       tc_w;
        logic [3:0] q_w;
        logic       wrap_w;
        logic       tc_s;
        logic [2:0] q_s;
        logic       wrap_s;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cw     = 0;
    int   cs     = 5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Counter as an integer on a ring of size mx+1.
    function automatic void model(input int cnt, input int mx,
                                  input bit sat, input bit e, input bit u,
                                  input bit c, input bit l, input int dv,
                                  input int rv, output int nxt,
                                  output bit wr, output bit tcv);
        int at_edge;
        at_edge = u ? mx : 0;
        tcv = e && (cnt == at_edge);
        wr  = 1'b0;
        nxt = cnt;
        if (c) begin
            nxt = rv;
        end else if (l) begin
            nxt = dv;
        end else if (e) begin
            if (tcv && sat) begin
                nxt = cnt;
            end else begin
                nxt = u ? (cnt + 1) % (mx + 1) : (cnt + mx) % (mx + 1);
                wr  = tcv;
            end
        end
    endfunction

    task automatic drive(input bit e, input bit u, input bit c,
                         input bit l, input logic [3:0] dv);
        exp_t x;
        int   n;
        bit   w;
        bit   t;
        @(negedge clk);
        en    = e;
        up_dn = u;
        clr   = c;
        load  = l;
        d     = dv;
        model(cw, 15, 1'b0, e, u, c, l, int'(dv), 0, n, w, t);
        x.tc_w   = t;
        x.q_w    = n[3:0];
        x.wrap_w = w;
        cw       = n;
        model(cs, 7, 1'b1, e, u, c, l, int'(dv[2:0]), 5, n, w, t);
        x.tc_s   = t;
        x.q_s    = n[2:0];
        x.wrap_s = w;
        cs       = n;
        q_exp.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        logic tcw;
        logic tcs;
        forever begin
            @(posedge clk);
            if (q_exp.size() > 0) begin
                x   = q_exp.pop_front();
                tcw = tc_w;
                tcs = tc_s;
                #1;
                chk("tc_w", 32'(tcw), 32'(x.tc_w));
                chk("q_w", 32'(q_w), 32'(x.q_w));
                chk("wrap_w", 32'(wrap_w), 32'(x.wrap_w));
                chk("tc_s", 32'(tcs), 32'(x.tc_s));
                chk("q_s", 32'(q_s), 32'(x.q_s));
                chk("wrap_s", 32'(wrap_s), 32'(x.wrap_s));
            end
        end
    end

    initial begin : stim
        bit u;
        int budget;
        reset_n = 1'b0;
        en      = 1'b0;
        up_dn   = 1'b1;
        clr     = 1'b0;
        load    = 1'b0;
        d       = '0;
        #12;
        chk("rst_q_w", 32'(q_w), 32'd0);
        chk("rst_wrap_w", 32'(wrap_w), 32'd0);
        chk("rst_q_s", 32'(q_s), 32'd5);
        chk("rst_wrap_s", 32'(wrap_s), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        repeat (16) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd15);

        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        repeat (10) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd6);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        #8;
        reset_n = 1'b0;
        #1;
        chk("async_q_w", 32'(q_w), 32'd0);
        chk("async_q_s", 32'(q_s), 32'd5);
        chk("async_wrap_w", 32'(wrap_w), 32'd0);
        cw = 0;
        cs = 5;
        reset_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        u = 1'b1;
        repeat (500) begin
            if ($urandom_range(0, 15) == 0) u = ~u;
            drive($urandom_range(0, 9) < 8, u,
                  $urandom_range(0, 31) == 0,
                  $urandom_range(0, 19) == 0,
                  4'($urandom_range(0, 15)));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        budget = 10;
        while (q_exp.size() > 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        chk("drain", 32'(q_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
